// File: rtl/mod12_hour_display.sv
// Two-digit multiplexed hour display for a mod-12 counter: maps count 0..11 to
// hours 12,1..11, tracks AM/PM across 11->0 rollovers and flags out-of-range input.
module mod12_hour_display #(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] q_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       pm,
    output logic       wrap_pulse,
    output logic       range_err
);

    localparam logic [7:0] RC_LAST = 8'(REFRESH_DIV - 1);

    logic [3:0] r_q_d;
    logic       r_pm;
    logic       r_wrap;
    logic       r_range_err;
    logic [7:0] r_rc;
    logic       r_digit_sel;
    logic [6:0] r_seg;
    logic [1:0] r_an;

    logic       w_in_range;
    logic       w_wrap;
    logic       w_rc_last;
    logic [3:0] w_hour;
    logic [3:0] w_units;
    logic       w_tens_blank;
    logic [6:0] w_next_seg;
    logic [1:0] w_next_an;

    // Decimal digit to {g,f,e,d,c,b,a} segment pattern; non-digits go dark.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_code = 7'b0111111;
            4'd1:    seg_code = 7'b0000110;
            4'd2:    seg_code = 7'b1011011;
            4'd3:    seg_code = 7'b1001111;
            4'd4:    seg_code = 7'b1100110;
            4'd5:    seg_code = 7'b1101101;
            4'd6:    seg_code = 7'b1111101;
            4'd7:    seg_code = 7'b0000111;
            4'd8:    seg_code = 7'b1111111;
            4'd9:    seg_code = 7'b1101111;
            default: seg_code = 7'b0000000;
        endcase
    endfunction

    assign w_in_range = (q_in <= 4'd11);
    // Only a true 11->0 count step is a rollover; a plain load of 0 is not.
    assign w_wrap     = w_in_range && (q_in == 4'd0) && (r_q_d == 4'd11);
    assign w_rc_last  = (r_rc == RC_LAST);

    // Hour mapping, digit split and next segment/anode pattern for the current digit.
    always_comb begin
        w_hour       = 4'd0;
        w_units      = 4'd0;
        w_tens_blank = 1'b1;
        w_next_seg   = 7'b0000000;
        w_next_an    = 2'b01;
        w_hour = (r_q_d == 4'd0) ? 4'd12 : r_q_d;
        if (w_hour >= 4'd10) begin
            w_tens_blank = 1'b0;
            w_units      = w_hour - 4'd10;
        end else begin
            w_tens_blank = 1'b1;
            w_units      = w_hour;
        end
        if (r_digit_sel) begin
            w_next_an  = 2'b10;
            w_next_seg = w_tens_blank ? 7'b0000000 : seg_code(4'd1);
        end else begin
            w_next_an  = 2'b01;
            w_next_seg = seg_code(w_units);
        end
    end

    // Count value, half-day flag and the one-cycle event flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q_d       <= 4'd0;
            r_pm        <= 1'b0;
            r_wrap      <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_range_err <= !w_in_range;
            r_wrap      <= w_wrap;
            if (w_wrap) begin
                r_pm <= !r_pm;
            end
            if (w_in_range) begin
                r_q_d <= q_in;
            end
        end
    end

    // Free-running digit scan and registered display drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rc        <= 8'd0;
            r_digit_sel <= 1'b0;
            r_seg       <= 7'b0000000;
            r_an        <= 2'b00;
        end else begin
            r_seg <= w_next_seg;
            r_an  <= w_next_an;
            if (w_rc_last) begin
                r_rc        <= 8'd0;
                r_digit_sel <= !r_digit_sel;
            end else begin
                r_rc <= r_rc + 8'd1;
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign pm         = r_pm;
    assign wrap_pulse = r_wrap;
    assign range_err  = r_range_err;

endmodule

// File: tb/tb_mod12_hour_display.sv
// Self-checking bench for mod12_hour_display: directed scenarios plus randomized
// counting, compared every cycle against an arithmetic model of the display.
module tb_mod12_hour_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       pm;
    logic       wrap_pulse;
    logic       range_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_q = 0;
    int         m_pm = 0;
    int         m_n = 0;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_pm;
    logic       e_wrap;
    logic       e_rerr;
    logic [6:0] codes [10];
    int         wraps = 0;
    logic       prev_wrap = 1'b0;

    mod12_hour_display #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .q_in(q_in), .seg(seg), .an(an),
        .pm(pm), .wrap_pulse(wrap_pulse), .range_err(range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance the model by one clock edge with input v.
    task automatic model_edge(input int v);
        int hour;
        int sel;
        m_n++;
        sel  = ((m_n - 1) / DIV) % 2;
        hour = (m_q == 0) ? 12 : m_q;
        e_an = (sel == 1) ? 2'b10 : 2'b01;
        if (sel == 1) e_seg = (hour >= 10) ? codes[1] : 7'b0000000;
        else          e_seg = codes[hour % 10];
        e_rerr = (v >= 12);
        e_wrap = (v == 0) && (m_q == 11);
        if (e_wrap) m_pm = 1 - m_pm;
        if (v <= 11) m_q = v;
        e_pm = (m_pm == 1);
    endtask

    task automatic step(input string tag, input int v);
        q_in = 4'(v);
        @(posedge clk);
        model_edge(v);
        #1;
        chk({tag, ".seg"}, {1'b0, seg}, {1'b0, e_seg});
        chk({tag, ".an"}, {6'd0, an}, {6'd0, e_an});
        chk({tag, ".pm"}, {7'd0, pm}, {7'd0, e_pm});
        chk({tag, ".wrap"}, {7'd0, wrap_pulse}, {7'd0, e_wrap});
        chk({tag, ".rerr"}, {7'd0, range_err}, {7'd0, e_rerr});
        chk({tag, ".wrapwidth"}, {7'd0, prev_wrap & wrap_pulse}, 8'd0);
        prev_wrap = wrap_pulse;
        if (wrap_pulse) wraps++;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".seg"}, {1'b0, seg}, 8'd0);
        chk({tag, ".an"}, {6'd0, an}, 8'd0);
        chk({tag, ".pm"}, {7'd0, pm}, 8'd0);
        chk({tag, ".wrap"}, {7'd0, wrap_pulse}, 8'd0);
        chk({tag, ".rerr"}, {7'd0, range_err}, 8'd0);
    endtask

    task automatic model_reset();
        m_q = 0; m_pm = 0; m_n = 0; prev_wrap = 1'b0;
    endtask

    initial begin
        int v;
        int mode;
        codes[0] = 7'b0111111; codes[1] = 7'b0000110; codes[2] = 7'b1011011;
        codes[3] = 7'b1001111; codes[4] = 7'b1100110; codes[5] = 7'b1101101;
        codes[6] = 7'b1111101; codes[7] = 7'b0000111; codes[8] = 7'b1111111;
        codes[9] = 7'b1101111;

        // Reset held
        #23;
        check_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();

        // Idle at hour 12: scan alternates, first edge shows units 2
        for (int i = 0; i < 20; i++) step("idle12", 0);

        // Full count 0..11 then 0
        wraps = 0;
        for (int h = 0; h < 12; h++)
            for (int k = 0; k < 8; k++) step("count", h);
        for (int k = 0; k < 8; k++) step("count_wrap", 0);
        chk("count_wrap_total", 8'(wraps), 8'd1);
        chk("count_pm_set", {7'd0, pm}, 8'd1);

        // Load-style transition into 0
        wraps = 0;
        for (int k = 0; k < 5; k++) step("load3", 3);
        for (int k = 0; k < 10; k++) step("load0", 0);
        chk("load_no_wrap", 8'(wraps), 8'd0);

        // Out-of-range input holds the display
        for (int k = 0; k < 8; k++) step("hold7", 7);
        for (int k = 0; k < 2; k++) step("range13", 13);
        for (int k = 0; k < 8; k++) step("after8", 8);

        // Reset mid-count with q_d = 11 and pm = 1, between edges
        for (int k = 0; k < 3; k++) step("pre_rst11", 11);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("mid_reset");
        @(posedge clk); #1;
        check_reset_state("mid_reset_held");
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 10; k++) step("post_rst", 0);

        // Two rollovers
        wraps = 0;
        for (int r = 0; r < 2; r++)
            for (int h = 1; h <= 12; h++) begin
                step("roll", h % 12);
                step("roll", h % 12);
            end
        chk("roll_total", 8'(wraps), 8'd2);
        chk("roll_pm", {7'd0, pm}, 8'd0);

        // Randomized mix of counting, loads and out-of-range samples
        for (int i = 0; i < 600; i++) begin
            mode = $urandom_range(0, 7);
            if (mode < 5)      v = (m_q + 1) % 12;
            else if (mode < 7) v = $urandom_range(0, 11);
            else               v = $urandom_range(12, 15);
            step("rand", v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod12_hour_display.md
MOD12_HOUR_DISPLAY -- requirements
Module: mod12_hour_display

Interface
REQ-001 Parameter REFRESH_DIV, default 4: clock cycles each display digit stays enabled before the scan moves to the other digit; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 q_in  input  4  count value from the upstream mod-12 counter, sampled every clk edge.
REQ-005 seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
REQ-006 an  output  2  digit enable, active-high, one-hot: 2'b01 = units digit, 2'b10 = tens digit.
REQ-007 pm  output  1  half-day flag: 0 = AM, 1 = PM.
REQ-008 wrap_pulse  output  1  one-cycle pulse on each 11->0 count rollover.
REQ-009 range_err  output  1  one-cycle flag when q_in is out of range.

Function
REQ-010 The block SHALL register q_in into q_d on every edge where q_in <= 11.
REQ-011 When q_in >= 12, the block SHALL hold q_d unchanged, set range_err = 1 for that cycle, and suppress the wrap check.
REQ-012 range_err SHALL be 0 on every cycle after a sample with q_in <= 11.
REQ-013 Hour mapping SHALL be: hour = 12 when q_d = 0; hour = q_d when q_d = 1..11.
REQ-014 Digit split SHALL be: tens = 1 when hour >= 10, otherwise tens is blank; units = hour mod 10.
REQ-015 Wrap detect SHALL fire on an edge where q_d == 11 and the in-range q_in == 0: wrap_pulse = 1 for exactly one cycle and pm toggles on that same edge.
REQ-016 Any other transition into 0 (for example a load from 5 to 0) SHALL NOT toggle pm and SHALL NOT pulse wrap_pulse.
REQ-017 Holding q_in at 0 after a wrap SHALL NOT produce a further wrap (q_d is then 0, not 11).
REQ-018 Refresh counter rc SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-019 On each edge where rc == REFRESH_DIV-1, digit_sel SHALL toggle.
REQ-020 seg and an SHALL be registered together on every edge from the current digit_sel and the current q_d, giving 1-cycle latency from a q_d change to seg.
REQ-021 an and seg SHALL be mutually consistent in every cycle.
REQ-022 an SHALL be 2'b01 when digit_sel = 0 and 2'b10 when digit_sel = 1.
REQ-023 A blank tens digit SHALL drive seg = 7'b0000000 while an = 2'b10 remains asserted.
REQ-024 Segment codes SHALL be:
  0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110,
  5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
REQ-025 Simultaneous events: a wrap on the same edge as a digit_sel toggle SHALL apply both; seg reflects the new q_d and the new digit_sel on the following edge.
REQ-026 The scan SHALL run continuously, independent of q_in activity and of range_err.

Reset
REQ-027 While rst = 0, the block SHALL immediately force q_d = 0, pm = 0, wrap_pulse = 0, range_err = 0, rc = 0, digit_sel = 0, seg = 7'b0000000, an = 2'b00, with no clock required.
REQ-028 The first edge after rst rises SHALL drive an = 2'b01 and seg = 7'b1011011 (units "2" of hour 12) unless q_in updates q_d on that same edge.
REQ-029 Reset asserted mid-scan or mid-wrap SHALL abort any pending pulse.
REQ-030 pm SHALL return to 0 (AM) on reset.

Verification
REQ-031 Reset, then q_in = 0 held, REFRESH_DIV = 4 -> an alternates 01/10 every 4 cycles; seg = 1011011 on units, 0000110 on tens; pm = 0.
REQ-032 q_in steps 0..11 then 0, one value per 8 cycles -> hours 12, 1..11 display correctly; tens blank (seg = 0) for hours 1..9; exactly one wrap_pulse at 11->0; pm goes 0->1.
REQ-033 Drive q_in 3 then 0 (load style) -> no wrap_pulse; pm unchanged; display shows 12.
REQ-034 q_d = 7, then q_in = 13 for 2 cycles, then q_in = 8 -> range_err = 1 for those 2 cycles; display stays 7; then shows 8 with range_err = 0.
REQ-035 Assert rst low mid-count with q_d = 11 and pm = 1, between clock edges -> all outputs clear immediately; after release, pm = 0 and display shows 12.
REQ-036 Two full 11->0 rollovers -> two wrap_pulses; pm returns to 0; no pulse widths other than 1 cycle.
